// File: rtl/fu_scheduler_if.sv
// Issue/CDB handshake bundle between the RS issue stage and the functional-unit scheduler.
// Unit index order everywhere: 0 ALU_1, 1 ALU_2, 2 ALU_3, 3 MULT_1, 4 MULT_2, 5 LS_1, 6 LS_2, 7 BRANCH.
interface fu_scheduler_if;
    logic            squash;
    logic [2:0]      issue_valid;
    logic [2:0][2:0] issue_fu;
    logic [7:0]      fu_ready;
    logic [7:0]      cdb_req;
    logic [7:0]      cdb_gnt;
    logic            issue_err;

    modport master (
        output squash, issue_valid, issue_fu,
        input  fu_ready, cdb_req, cdb_gnt, issue_err
    );

    modport slave (
        input  squash, issue_valid, issue_fu,
        output fu_ready, cdb_req, cdb_gnt, issue_err
    );
endinterface

// File: rtl/fu_scheduler.sv
// Tracks occupancy and execution latency of the 8 functional units, arbitrates
// finished units onto the CDB and reports which units may be issued to.
module fu_scheduler #(
    parameter int ALU_LAT  = 1,
    parameter int MULT_LAT = 4,
    parameter int LS_LAT   = 2,
    parameter int BR_LAT   = 1,
    parameter int CDB_W    = 3
) (
    input logic           clock,
    input logic           reset,
    fu_scheduler_if.slave fuIf
);
    localparam int MAX_LAT_AM = (ALU_LAT > MULT_LAT) ? ALU_LAT : MULT_LAT;
    localparam int MAX_LAT_LB = (LS_LAT > BR_LAT) ? LS_LAT : BR_LAT;
    localparam int MAX_LAT    = (MAX_LAT_AM > MAX_LAT_LB) ? MAX_LAT_AM : MAX_LAT_LB;
    localparam int CW         = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } unitState_e;

    unitState_e    state_q [8];
    unitState_e    state_d [8];
    logic [CW-1:0] cnt_q   [8];
    logic [CW-1:0] cnt_d   [8];
    logic [1:0]    hits    [8];
    logic [7:0]    ready_q, ready_d;
    logic [7:0]    req_q, req_d;
    logic [7:0]    gnt;
    logic          issueErr_q, issueErr_d;

    function automatic int latOf(input int u);
        if (u < 3) return ALU_LAT;
        if (u < 5) return MULT_LAT;
        if (u < 7) return LS_LAT;
        return BR_LAT;
    endfunction

    // Number of issue slots aimed at each unit this cycle.
    always_comb begin
        for (int u = 0; u < 8; u++) begin
            hits[u] = 2'd0;
            for (int s = 0; s < 3; s++) begin
                if (fuIf.issue_valid[s] && (fuIf.issue_fu[s] == 3'(u))) begin
                    hits[u] = hits[u] + 2'd1;
                end
            end
        end
    end

    // Priority walk starts at MULT_1 (index 3) and wraps, so the ALUs come last.
    always_comb begin
        int         grantCount;
        logic [2:0] idx;
        gnt        = '0;
        grantCount = 0;
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k + 3);
            if (req_q[idx] && (grantCount < CDB_W)) begin
                gnt[idx]   = 1'b1;
                grantCount = grantCount + 1;
            end
        end
    end

    always_comb begin
        issueErr_d = issueErr_q;
        for (int u = 0; u < 8; u++) begin
            state_d[u] = state_q[u];
            cnt_d[u]   = cnt_q[u];
            if ((hits[u] > 2'd1) || ((hits[u] != 2'd0) && (state_q[u] != IDLE))) begin
                issueErr_d = 1'b1;
            end
            if (fuIf.squash) begin
                state_d[u] = IDLE;
                cnt_d[u]   = '0;
            end else begin
                unique case (state_q[u])
                    IDLE: begin
                        if (hits[u] != 2'd0) begin
                            if (latOf(u) == 1) begin
                                state_d[u] = DONE;
                                cnt_d[u]   = '0;
                            end else begin
                                state_d[u] = EXEC;
                                cnt_d[u]   = CW'(latOf(u) - 1);
                            end
                        end
                    end
                    EXEC: begin
                        // The edge that takes the counter to zero also enters DONE.
                        if (cnt_q[u] <= CW'(1)) begin
                            state_d[u] = DONE;
                            cnt_d[u]   = '0;
                        end else begin
                            cnt_d[u] = cnt_q[u] - CW'(1);
                        end
                    end
                    DONE: begin
                        if (gnt[u]) state_d[u] = IDLE;
                    end
                    default: begin
                        state_d[u] = IDLE;
                        cnt_d[u]   = '0;
                    end
                endcase
            end
            ready_d[u] = (state_d[u] == IDLE);
            req_d[u]   = (state_d[u] == DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int u = 0; u < 8; u++) begin
                state_q[u] <= IDLE;
                cnt_q[u]   <= '0;
            end
            ready_q    <= '1;
            req_q      <= '0;
            issueErr_q <= 1'b0;
        end else begin
            for (int u = 0; u < 8; u++) begin
                state_q[u] <= state_d[u];
                cnt_q[u]   <= cnt_d[u];
            end
            ready_q    <= ready_d;
            req_q      <= req_d;
            issueErr_q <= issueErr_d;
        end
    end

    assign fuIf.fu_ready  = ready_q;
    assign fuIf.cdb_req   = req_q;
    assign fuIf.cdb_gnt   = gnt;
    assign fuIf.issue_err = issueErr_q;
endmodule

// File: tb/tb_fu_scheduler.sv
// Self-checking bench for fu_scheduler: directed latency/arbitration/squash scenarios
// with hand-derived constants, then random traffic against a cycle-timestamp model.
module tb_fu_scheduler;
    localparam int CDB_W = 3;
    localparam int PRIO [8] = '{3, 4, 5, 6, 7, 0, 1, 2};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bit   mBusy   [8];
    int   mDoneAt [8];
    bit   mErr;

    fu_scheduler_if fuIf ();

    fu_scheduler #(
        .ALU_LAT (1),
        .MULT_LAT(4),
        .LS_LAT  (2),
        .BR_LAT  (1),
        .CDB_W   (CDB_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fuIf (fuIf)
    );

    always #5 clock = ~clock;

    function automatic int latOf(input int u);
        if (u < 3) return 1;
        if (u < 5) return 4;
        if (u < 7) return 2;
        return 1;
    endfunction

    function automatic logic [7:0] expReady();
        logic [7:0] r;
        for (int u = 0; u < 8; u++) r[u] = !mBusy[u];
        return r;
    endfunction

    // A unit holds a result once its timestamp has been reached and nobody granted it yet.
    function automatic logic [7:0] expReq();
        logic [7:0] r;
        for (int u = 0; u < 8; u++) r[u] = mBusy[u] && (cyc >= mDoneAt[u]);
        return r;
    endfunction

    function automatic logic [7:0] expGnt();
        logic [7:0] req;
        logic [7:0] g;
        int         n;
        req = expReq();
        g   = '0;
        n   = 0;
        for (int k = 0; k < 8; k++) begin
            if (req[PRIO[k]] && n < CDB_W) begin
                g[PRIO[k]] = 1'b1;
                n++;
            end
        end
        return g;
    endfunction

    // Drive one cycle of inputs, step across the edge and advance the model to match.
    task automatic applyStimulus(input logic r, input logic sq, input logic [2:0] v,
                                 input logic [2:0][2:0] f);
        logic [7:0] g;
        int         hits [8];
        reset            = r;
        fuIf.squash      = sq;
        fuIf.issue_valid = v;
        fuIf.issue_fu    = f;
        g = expGnt();
        for (int u = 0; u < 8; u++) hits[u] = 0;
        for (int s = 0; s < 3; s++) if (v[s]) hits[f[s]]++;
        @(posedge clock);
        if (r) begin
            for (int u = 0; u < 8; u++) mBusy[u] = 1'b0;
            mErr = 1'b0;
        end else begin
            for (int u = 0; u < 8; u++) begin
                if (hits[u] > 1 || (hits[u] > 0 && mBusy[u])) mErr = 1'b1;
            end
            for (int u = 0; u < 8; u++) begin
                if (sq) mBusy[u] = 1'b0;
                else if (g[u]) mBusy[u] = 1'b0;
                else if (hits[u] > 0 && !mBusy[u]) begin
                    mBusy[u]   = 1'b1;
                    mDoneAt[u] = cyc + latOf(u);
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 3'b111, {3'd0, 3'd0, 3'd3});
        checks++; if (fuIf.fu_ready !== 8'hFF) begin errors++; $display("[TB] FAIL reset_ready got %h want ff", fuIf.fu_ready); end
        checks++; if (fuIf.cdb_req !== 8'h00) begin errors++; $display("[TB] FAIL reset_req got %h want 00", fuIf.cdb_req); end
        checks++; if (fuIf.cdb_gnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_gnt got %h want 00", fuIf.cdb_gnt); end
        checks++; if (fuIf.issue_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", fuIf.issue_err); end
        idleCycle();
        checks++; if (fuIf.fu_ready !== 8'hFF || fuIf.cdb_req !== 8'h00) begin errors++; $display("[TB] FAIL reset_release ready %h req %h want ff 00", fuIf.fu_ready, fuIf.cdb_req); end
    endtask

    task automatic test_alu_latency();
        applyStimulus(1'b0, 1'b0, 3'b001, {3'd0, 3'd0, 3'd0});
        checks++; if (fuIf.fu_ready !== 8'hFE) begin errors++; $display("[TB] FAIL alu_busy_ready got %h want fe", fuIf.fu_ready); end
        checks++; if (fuIf.cdb_req !== 8'h01 || fuIf.cdb_gnt !== 8'h01) begin errors++; $display("[TB] FAIL alu_done req %h gnt %h want 01 01", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
        checks++; if (fuIf.fu_ready !== 8'hFF || fuIf.cdb_req !== 8'h00) begin errors++; $display("[TB] FAIL alu_reready ready %h req %h want ff 00", fuIf.fu_ready, fuIf.cdb_req); end
    endtask

    task automatic test_mult_latency();
        applyStimulus(1'b0, 1'b0, 3'b100, {3'd4, 3'd0, 3'd0});
        for (int i = 1; i <= 3; i++) begin
            checks++; if (fuIf.cdb_req !== 8'h00 || fuIf.fu_ready !== 8'hEF) begin errors++; $display("[TB] FAIL mult_exec_%0d req %h ready %h want 00 ef", i, fuIf.cdb_req, fuIf.fu_ready); end
            idleCycle();
        end
        checks++; if (fuIf.cdb_req !== 8'h10 || fuIf.cdb_gnt !== 8'h10) begin errors++; $display("[TB] FAIL mult_done req %h gnt %h want 10 10", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
        checks++; if (fuIf.fu_ready !== 8'hFF) begin errors++; $display("[TB] FAIL mult_reready got %h want ff", fuIf.fu_ready); end
    endtask

    task automatic test_cdb_overflow();
        applyStimulus(1'b0, 1'b0, 3'b011, {3'd0, 3'd6, 3'd5});
        applyStimulus(1'b0, 1'b0, 3'b111, {3'd7, 3'd1, 3'd0});
        checks++; if (fuIf.cdb_req !== 8'hE3 || fuIf.cdb_gnt !== 8'hE0) begin errors++; $display("[TB] FAIL overflow_first req %h gnt %h want e3 e0", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
        checks++; if (fuIf.cdb_req !== 8'h03 || fuIf.cdb_gnt !== 8'h03) begin errors++; $display("[TB] FAIL overflow_second req %h gnt %h want 03 03", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
        checks++; if (fuIf.fu_ready !== 8'hFF) begin errors++; $display("[TB] FAIL overflow_drain got %h want ff", fuIf.fu_ready); end
    endtask

    task automatic test_contention();
        applyStimulus(1'b0, 1'b0, 3'b011, {3'd0, 3'd4, 3'd3});
        idleCycle();
        applyStimulus(1'b0, 1'b0, 3'b001, {3'd0, 3'd0, 3'd5});
        applyStimulus(1'b0, 1'b0, 3'b010, {3'd0, 3'd0, 3'd0});
        checks++; if (fuIf.cdb_req !== 8'h39 || fuIf.cdb_gnt !== 8'h38) begin errors++; $display("[TB] FAIL contention_first req %h gnt %h want 39 38", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
        checks++; if (fuIf.cdb_req !== 8'h01 || fuIf.cdb_gnt !== 8'h01) begin errors++; $display("[TB] FAIL contention_alu req %h gnt %h want 01 01", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
    endtask

    task automatic test_illegal_squash();
        applyStimulus(1'b1, 1'b0, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 3'b001, {3'd0, 3'd0, 3'd3});
        applyStimulus(1'b0, 1'b0, 3'b001, {3'd0, 3'd0, 3'd3});
        checks++; if (fuIf.issue_err !== 1'b1) begin errors++; $display("[TB] FAIL busy_issue_err got %b want 1", fuIf.issue_err); end
        idleCycle();
        idleCycle();
        checks++; if (fuIf.cdb_req !== 8'h08) begin errors++; $display("[TB] FAIL busy_issue_ignored req %h want 08", fuIf.cdb_req); end
        idleCycle();
        applyStimulus(1'b1, 1'b0, 3'b000, '0);
        applyStimulus(1'b0, 1'b0, 3'b011, {3'd0, 3'd5, 3'd5});
        checks++; if (fuIf.issue_err !== 1'b1 || fuIf.fu_ready !== 8'hDF) begin errors++; $display("[TB] FAIL double_issue err %b ready %h want 1 df", fuIf.issue_err, fuIf.fu_ready); end
        idleCycle();
        checks++; if (fuIf.cdb_req !== 8'h20 || fuIf.cdb_gnt !== 8'h20) begin errors++; $display("[TB] FAIL double_issue_once req %h gnt %h want 20 20", fuIf.cdb_req, fuIf.cdb_gnt); end
        idleCycle();
        applyStimulus(1'b0, 1'b0, 3'b001, {3'd0, 3'd0, 3'd3});
        idleCycle();
        applyStimulus(1'b0, 1'b1, 3'b001, {3'd0, 3'd0, 3'd1});
        checks++; if (fuIf.fu_ready !== 8'hFF || fuIf.cdb_req !== 8'h00) begin errors++; $display("[TB] FAIL squash ready %h req %h want ff 00", fuIf.fu_ready, fuIf.cdb_req); end
        checks++; if (fuIf.issue_err !== 1'b1) begin errors++; $display("[TB] FAIL squash_err got %b want 1", fuIf.issue_err); end
        idleCycle();
        checks++; if (fuIf.cdb_req !== 8'h00) begin errors++; $display("[TB] FAIL squash_discard req %h want 00", fuIf.cdb_req); end
    endtask

    task automatic test_random();
        logic [2:0]      v;
        logic [2:0][2:0] f;
        logic            sq;
        logic            r;
        for (int i = 0; i < 400; i++) begin
            v  = 3'($urandom_range(0, 7));
            f  = 9'($urandom);
            sq = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 63) == 0);
            applyStimulus(r, sq, v, f);
            checks++;
            if ({fuIf.fu_ready, fuIf.cdb_req, fuIf.cdb_gnt, fuIf.issue_err} !== {expReady(), expReq(), expGnt(), mErr}) begin
                errors++;
                $display("[TB] FAIL random_%0d ready/req/gnt/err got %h %h %h %b want %h %h %h %b", i,
                         fuIf.fu_ready, fuIf.cdb_req, fuIf.cdb_gnt, fuIf.issue_err,
                         expReady(), expReq(), expGnt(), mErr);
            end
        end
    endtask

    initial begin
        fuIf.squash      = 1'b0;
        fuIf.issue_valid = '0;
        fuIf.issue_fu    = '0;
        test_reset();
        test_alu_latency();
        test_mult_latency();
        test_cdb_overflow();
        test_contention();
        test_illegal_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
